mult_div_unit: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle ALU: an iterative multiply/divide unit with HI/LO result registers for the MIPS datapath.
- Executes MULTU, MULT, DIVU and DIV over WIDTH-bit operands.
  - Multiply is radix-2 shift-add; divide is radix-2 restoring.
- Uses a start/done handshake and sets n, z, v and divide-by-zero flags.
- Sits beside the ALU in the execute stage. The hazard unit stalls on `ready` = 0.

---
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the execute stage and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] port_a;
  logic [WIDTH-1:0] port_b;
  logic             flush;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             n;
  logic             z;
  logic             v;
  logic             dz;

  modport master (
    output start, op, port_a, port_b, flush,
    input  ready, done, hi, lo, n, z, v, dz
  );

  modport slave (
    input  start, op, port_a, port_b, flush,
    output ready, done, hi, lo, n, z, v, dz
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiply is radix-2 shift-add, divide is radix-2 restoring; signed ops run on
// magnitudes and get their signs restored in the FIX state. Every op takes the
// same number of cycles, including divide-by-zero and signed overflow.
module mult_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNTW  = $clog2(WIDTH) + 1
) (
  input logic            CLK,
  input logic            nRST,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0]       OP_DIV   = 2'b11;
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNTW-1:0]  CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0]  CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(WIDTH);

  // Two's-complement negation of a single-width word.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  // Two's-complement negation of a double-width product.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // State and datapath registers
  state_t             state_q;
  logic [CNTW-1:0]    cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     rem_q;
  logic               prod_neg_q;
  logic               rem_neg_q;
  logic               b_neg_q;

  // Registered outputs
  logic               ready_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               n_q;
  logic               z_q;
  logic               v_q;
  logic               dz_q;

  // Combinational helpers
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic               quo_bit_s;
  logic [WIDTH:0]     rem_d;
  logic [2*WIDTH-1:0] div_acc_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic               n_d;
  logic               z_d;
  logic               v_d;
  logic               dz_d;

  // Operand signs and magnitudes captured when a request is accepted.
  always_comb begin
    a_neg_s = bus.op[0] & bus.port_a[WIDTH-1];
    b_neg_s = bus.op[0] & bus.port_b[WIDTH-1];
    if (a_neg_s) begin
      a_abs_s = neg_w(bus.port_a);
    end else begin
      a_abs_s = bus.port_a;
    end
    if (b_neg_s) begin
      b_abs_s = neg_w(bus.port_b);
    end else begin
      b_abs_s = bus.port_b;
    end
  end

  // One shift-add multiply step: add multiplicand into the upper half when
  // the multiplier LSB is set, then shift the whole accumulator right.
  always_comb begin
    if (acc_q[0]) begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    end else begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    mul_acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
  end

  // One restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor only if it fits.
  always_comb begin
    div_shift_s = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opb_q};
    if (div_shift_s >= {1'b0, opb_q}) begin
      rem_d     = div_trial_s;
      quo_bit_s = 1'b1;
    end else begin
      rem_d     = div_shift_s;
      quo_bit_s = 1'b0;
    end
    div_acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], quo_bit_s};
    if (op_q[1]) begin
      acc_d = div_acc_d;
    end else begin
      acc_d = mul_acc_d;
    end
  end

  // Sign correction and special-case resolution producing the FIX-state results.
  always_comb begin
    if (prod_neg_q) begin
      prod_s = neg_2w(acc_q);
    end else begin
      prod_s = acc_q;
    end
    if (prod_neg_q) begin
      quo_s = neg_w(acc_q[WIDTH-1:0]);
    end else begin
      quo_s = acc_q[WIDTH-1:0];
    end
    if (rem_neg_q) begin
      rem_s = neg_w(rem_q[WIDTH-1:0]);
    end else begin
      rem_s = rem_q[WIDTH-1:0];
    end
    ovf_s = (op_q == OP_DIV) && (a_raw_q == MIN_W) && b_neg_q && (opb_q == ONE_W);

    v_d  = 1'b0;
    dz_d = 1'b0;
    if (!op_q[1]) begin
      hi_d = prod_s[2*WIDTH-1:WIDTH];
      lo_d = prod_s[WIDTH-1:0];
    end else if (opb_q == ZERO_W) begin
      hi_d = a_raw_q;
      lo_d = ONES_W;
      dz_d = 1'b1;
    end else if (ovf_s) begin
      hi_d = ZERO_W;
      lo_d = MIN_W;
      v_d  = 1'b1;
    end else begin
      hi_d = rem_s;
      lo_d = quo_s;
    end

    if (op_q[1]) begin
      n_d = lo_d[WIDTH-1];
    end else begin
      n_d = hi_d[WIDTH-1];
    end
    z_d = (hi_d == ZERO_W) && (lo_d == ZERO_W);
  end

  // Control FSM with registered handshake outputs and HI/LO/flag registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      op_q       <= 2'b00;
      a_raw_q    <= ZERO_W;
      opb_q      <= ZERO_W;
      acc_q      <= {(2*WIDTH){1'b0}};
      rem_q      <= {(WIDTH+1){1'b0}};
      prod_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      b_neg_q    <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      hi_q       <= ZERO_W;
      lo_q       <= ZERO_W;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      v_q        <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q       <= bus.op;
            a_raw_q    <= bus.port_a;
            opb_q      <= b_abs_s;
            acc_q      <= {ZERO_W, a_abs_s};
            rem_q      <= {(WIDTH+1){1'b0}};
            prod_neg_q <= a_neg_s ^ b_neg_s;
            rem_neg_q  <= a_neg_s;
            b_neg_q    <= b_neg_s;
            cnt_q      <= CNT_ZERO;
            ready_q    <= 1'b0;
            state_q    <= S_BUSY;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_BUSY: begin
          if (bus.flush) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end else begin
            acc_q <= acc_d;
            if (op_q[1]) begin
              rem_q <= rem_d;
            end else begin
              rem_q <= rem_q;
            end
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_FIX: begin
          if (bus.flush) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            n_q     <= n_d;
            z_q     <= z_d;
            v_q     <= v_d;
            dz_q    <= dz_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.n     = n_q;
  assign bus.z     = z_q;
  assign bus.v     = v_q;
  assign bus.dz    = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random operands,
// compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic CLK = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [W-1:0] exp_hi, exp_lo;
  logic         exp_n, exp_z, exp_v, exp_dz;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_word({tag, "_hi"}, bus.hi, exp_hi);
    check_word({tag, "_lo"}, bus.lo, exp_lo);
    check_bit({tag, "_n"}, bus.n, exp_n);
    check_bit({tag, "_z"}, bus.z, exp_z);
    check_bit({tag, "_v"}, bus.v, exp_v);
    check_bit({tag, "_dz"}, bus.dz, exp_dz);
  endtask

  // Reference model: results straight from integer arithmetic.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] h, output logic [W-1:0] l,
                       output logic nn, output logic zz, output logic vv, output logic dd);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    vv = 1'b0;
    dd = 1'b0;
    h  = '0;
    l  = '0;
    if (op == 2'b00) begin
      p = {32'h0, a} * {32'h0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (op == 2'b01) begin
      p = 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'h0) begin
      dd = 1'b1;
      l  = 32'hFFFF_FFFF;
      h  = a;
    end else if (op == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      vv = 1'b1;
      l  = 32'h8000_0000;
      h  = 32'h0;
    end else if (op == 2'b10) begin
      l = a / b;
      h = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
    nn = op[1] ? l[W-1] : h[W-1];
    zz = (h == 32'h0) && (l == 32'h0);
  endtask

  // Issue one operation and follow it cycle by cycle. restart_at/flush_at/rst_at
  // give the edge offset (after the accepting edge) at which a second start,
  // a flush or a reset is applied; -1 disables each.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int restart_at, input int flush_at, input int rst_at,
                        input bit fl_with_start);
    logic [W-1:0] m_hi, m_lo;
    logic         m_n, m_z, m_v, m_dz;
    bit           seen_done, flushed, aborted, late_done;
    model(op, a, b, m_hi, m_lo, m_n, m_z, m_v, m_dz);
    check_bit("ready_before_start", bus.ready, 1'b1);
    bus.op     = op;
    bus.port_a = a;
    bus.port_b = b;
    bus.start  = 1'b1;
    bus.flush  = fl_with_start;
    seen_done  = 1'b0;
    flushed    = 1'b0;
    aborted    = 1'b0;
    for (int k = 0; k <= LAT + 4 && !seen_done && !aborted; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        bus.port_a = $urandom;
        bus.port_b = $urandom;
        bus.op     = 2'($urandom);
        check_bit("accept_ready_low", bus.ready, 1'b0);
      end
      if (k == flush_at) begin
        check_bit("flush_ready", bus.ready, 1'b1);
        check_bit("flush_no_done", bus.done, 1'b0);
        check_outputs("flush_hold");
        flushed = 1'b1;
        aborted = 1'b1;
      end else if (k == rst_at) begin
        nRST = 1'b1;
        check_bit("rst_ready", bus.ready, 1'b1);
        check_bit("rst_done", bus.done, 1'b0);
        exp_hi = '0; exp_lo = '0;
        exp_n = 1'b0; exp_z = 1'b0; exp_v = 1'b0; exp_dz = 1'b0;
        check_outputs("rst_clear");
        aborted = 1'b1;
      end else if (bus.done === 1'b1) begin
        seen_done = 1'b1;
        check_int("latency", k, LAT);
        exp_hi = m_hi; exp_lo = m_lo;
        exp_n = m_n; exp_z = m_z; exp_v = m_v; exp_dz = m_dz;
        check_outputs("result");
      end else if (k == 2) begin
        check_outputs("hold_busy");
      end
      if (!aborted && !seen_done) begin
        bus.start = (k + 1 == restart_at);
        bus.flush = (k + 1 == flush_at);
        nRST      = (k + 1 == rst_at) ? 1'b0 : 1'b1;
      end else begin
        bus.start = 1'b0;
        bus.flush = 1'b0;
      end
    end
    if (!aborted) begin
      check_bit("done_seen", seen_done, 1'b1);
    end
    if (seen_done) begin
      // start and flush during the DONE cycle must both be ignored
      bus.start  = 1'b1;
      bus.flush  = 1'b1;
      bus.port_a = $urandom;
      bus.port_b = $urandom;
      @(negedge CLK);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check_bit("post_done_ready", bus.ready, 1'b1);
      check_bit("post_done_pulse", bus.done, 1'b0);
      check_outputs("post_done_hold");
      @(negedge CLK);
      check_bit("done_start_not_queued", bus.ready, 1'b1);
    end
    if (flushed) begin
      late_done = 1'b0;
      repeat (LAT + 6) begin
        @(negedge CLK);
        if (bus.done === 1'b1) late_done = 1'b1;
      end
      check_bit("no_done_after_flush", late_done, 1'b0);
      check_word("flush_later_lo", bus.lo, exp_lo);
    end
  endtask

  initial begin
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    int           sel;
    nRST       = 1'b0;
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.op     = 2'b11;
    bus.port_a = 32'h1234_5678;
    bus.port_b = 32'h0;
    repeat (2) @(negedge CLK);
    exp_hi = '0; exp_lo = '0;
    exp_n = 1'b0; exp_z = 1'b0; exp_v = 1'b0; exp_dz = 1'b0;
    check_bit("reset_ready", bus.ready, 1'b1);
    check_bit("reset_done", bus.done, 1'b0);
    check_outputs("reset");
    nRST      = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge CLK);
    check_bit("reset_idle_ready", bus.ready, 1'b1);

    // Directed cases
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5,        -1, -1, -1, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0,        -1, -1, -1, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2,        -1, -1, -1, 1'b0);
    run_op(2'b10, 32'd100,       32'd7,        -1, -1, -1, 1'b1);
    run_op(2'b10, 32'd100,       32'h0,        -1, -1, -1, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0,        -1, -1, -1, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'd1,        -1, -1, -1, 1'b0);
    run_op(2'b01, 32'd3,         32'd4,         5, -1, -1, 1'b0);
    run_op(2'b11, 32'hDEAD_BEEF, 32'd13,       -1, 10, -1, 1'b0);
    run_op(2'b10, 32'hCAFE_F00D, 32'd9,        -1, -1, 20, 1'b0);
    run_op(2'b10, 32'd1000,      32'd3,        -1, -1, -1, 1'b0);

    // Random operands against the model
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      sel  = $urandom_range(0, 5);
      if (sel == 0)      r_b = 32'h0;
      else if (sel == 1) r_b = 32'($urandom_range(1, 9));
      else if (sel == 2) r_b = 32'hFFFF_FFFF;
      else               r_b = 32'($urandom);
      run_op(r_op, r_a, r_b, -1, -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
